// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin arbiter/sequencer sharing one bank of
// single-word tri-state registers between several requesters. A winner is
// latched in IDLE, served in ACCESS until a Tick edge, and acknowledged in
// RELEASE with a one-cycle Done pulse.
module regbank_arbiter #(
  parameter int NrOfReq  = 4,
  parameter int NrOfRegs = 8,
  parameter int NrOfBits = 8,
  parameter int AddrBits = 3
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Tick,
  input  logic [NrOfReq-1:0]           Req,
  input  logic [NrOfReq-1:0]           ReqWrite,
  input  logic [NrOfReq*AddrBits-1:0]  ReqAddr,
  input  logic [NrOfReq*NrOfBits-1:0]  ReqWData,
  output logic [NrOfReq-1:0]           Grant,
  output logic [NrOfReq-1:0]           Done,
  output logic                         Err,
  output logic [NrOfBits-1:0]          RdData,
  output logic [NrOfRegs-1:0]          RegCE,
  output logic [NrOfRegs-1:0]          RegCs,
  output logic [NrOfBits-1:0]          RegD,
  input  logic [NrOfBits-1:0]          RegQ
);

  localparam int IdxW = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t                r_state;
  logic [IdxW-1:0]       r_ptr;
  logic [IdxW-1:0]       r_winner;
  logic                  r_write;
  logic [AddrBits-1:0]   r_addr;
  logic [NrOfBits-1:0]   r_wdata;
  logic [NrOfBits-1:0]   r_rddata;

  logic                  w_found;
  logic [IdxW-1:0]       w_win;
  logic                  w_write;
  logic [AddrBits-1:0]   w_addr;
  logic [NrOfBits-1:0]   w_wdata;
  logic                  w_valid;

  // Round-robin search: first set Req bit at ptr, ptr+1, ... modulo NrOfReq
  always_comb begin
    logic [IdxW:0] w_sum;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NrOfReq; k++) begin
      w_sum = {1'b0, r_ptr} + (IdxW+1)'(k);
      if (w_sum >= (IdxW+1)'(NrOfReq)) w_sum = w_sum - (IdxW+1)'(NrOfReq);
      if (!w_found && Req[w_sum[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IdxW-1:0];
      end
    end
  end

  // Select the candidate winner's request fields for latching
  always_comb begin
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NrOfReq; i++) begin
      if (IdxW'(i) == w_win) begin
        w_write = ReqWrite[i];
        w_addr  = ReqAddr[i*AddrBits +: AddrBits];
        w_wdata = ReqWData[i*NrOfBits +: NrOfBits];
      end
    end
  end

  // Out-of-range addresses never touch the bank and finish with Err
  assign w_valid = ({1'b0, r_addr} < (AddrBits+1)'(NrOfRegs));

  // Sequencer FSM; request fields are latched so later input changes are ignored
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_rddata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_winner <= w_win;
            r_write  <= w_write;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (!w_valid) begin
            r_state <= RELEASE;
          end else if (Tick) begin
            if (!r_write) r_rddata <= RegQ;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_ptr   <= (r_winner == IdxW'(NrOfReq-1)) ? '0 : r_winner + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bank control decoded from state and latched fields only
  always_comb begin
    Grant = '0;
    Done  = '0;
    RegCE = '0;
    RegCs = '1;
    RegD  = '0;
    Err   = (r_state == RELEASE) && !w_valid;
    for (int i = 0; i < NrOfReq; i++) begin
      if (IdxW'(i) == r_winner) begin
        Grant[i] = (r_state == ACCESS);
        Done[i]  = (r_state == RELEASE);
      end
    end
    if (r_state == ACCESS && w_valid) begin
      if (r_write) RegD = r_wdata;
      for (int j = 0; j < NrOfRegs; j++) begin
        if (AddrBits'(j) == r_addr) begin
          if (r_write) RegCE[j] = 1'b1;
          else         RegCs[j] = 1'b0;
        end
      end
    end
  end

  assign RdData = r_rddata;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Testbench for regbank_arbiter: directed transaction table, multi-cycle
// corner sequences and a randomized bus-exclusivity run.
module tb_regbank_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Tick  = 1'b0;
  logic [3:0]  Req = '0, ReqWrite = '0;
  logic [11:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic [3:0]  Grant, Done;
  logic        Err;
  logic [7:0]  RdData, RegCE, RegCs, RegD, RegQ;

  logic        Tick_b = 1'b0;
  logic [3:0]  Req_b = '0, ReqWrite_b = '0;
  logic [11:0] ReqAddr_b = '0;
  logic [31:0] ReqWData_b = '0;
  logic [3:0]  Grant_b, Done_b;
  logic        Err_b;
  logic [7:0]  RdData_b, RegD_b, RegQ_b;
  logic [5:0]  RegCE_b, RegCs_b;

  int n_tests = 0;
  int n_fail  = 0;

  regbank_arbiter #(.NrOfReq(4), .NrOfRegs(8), .NrOfBits(8), .AddrBits(3)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Req(Req), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .Grant(Grant), .Done(Done), .Err(Err),
    .RdData(RdData), .RegCE(RegCE), .RegCs(RegCs), .RegD(RegD), .RegQ(RegQ));

  regbank_arbiter #(.NrOfReq(4), .NrOfRegs(6), .NrOfBits(8), .AddrBits(3)) dut_b (
    .Clock(Clock), .Reset(Reset), .Tick(Tick_b), .Req(Req_b), .ReqWrite(ReqWrite_b),
    .ReqAddr(ReqAddr_b), .ReqWData(ReqWData_b), .Grant(Grant_b), .Done(Done_b), .Err(Err_b),
    .RdData(RdData_b), .RegCE(RegCE_b), .RegCs(RegCs_b), .RegD(RegD_b), .RegQ(RegQ_b));

  always #5 Clock = ~Clock;

  // Register bank model: commit on Tick && ClockEnable, wired-OR read bus
  logic [7:0] bank [0:7] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77};
  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) if (Tick && RegCE[i]) bank[i] <= RegD;
  end
  always_comb begin
    RegQ = '0;
    for (int i = 0; i < 8; i++) if (!RegCs[i]) RegQ = RegQ | bank[i];
  end
  assign RegQ_b = (RegCs_b != 6'h3F) ? 8'h3C : 8'h00;

  typedef struct {
    int         r;
    logic       wr;
    logic [2:0] a;
    logic [7:0] d;
    logic [3:0] g;
    logic [7:0] ce;
    logic [7:0] cs;
    logic [7:0] dbus;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    Req = '0;
    Req[v.r] = 1'b1;
    ReqWrite[v.r] = v.wr;
    ReqAddr[v.r*3 +: 3] = v.a;
    ReqWData[v.r*8 +: 8] = v.d;
    step();
    Req = '0;
    ReqAddr = '1;
    ReqWData = '1;
    #1;
    check("txn_grant", 32'(Grant), 32'(v.g));
    check("txn_ce",    32'(RegCE), 32'(v.ce));
    check("txn_cs",    32'(RegCs), 32'(v.cs));
    check("txn_d",     32'(RegD),  32'(v.dbus));
    step();
    check("txn_done",  32'(Done),   32'(v.g));
    check("txn_err",   32'(Err),    32'(0));
    check("txn_rd",    32'(RdData), 32'(v.rd));
    check("txn_rel_grant", 32'(Grant), 32'(0));
    step();
    check("txn_idle_done", 32'(Done), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_done;
    // r, wr, a, d, grant, ce, cs, dbus, rd
    tbl[0] = '{0, 1'b1, 3'd3, 8'hA5, 4'b0001, 8'h08, 8'hFF, 8'hA5, 8'h00};
    tbl[1] = '{0, 1'b0, 3'd3, 8'h00, 4'b0001, 8'h00, 8'hF7, 8'h00, 8'hA5};
    tbl[2] = '{2, 1'b1, 3'd7, 8'h3C, 4'b0100, 8'h80, 8'hFF, 8'h3C, 8'hA5};
    tbl[3] = '{3, 1'b1, 3'd0, 8'h81, 4'b1000, 8'h01, 8'hFF, 8'h81, 8'hA5};
    tbl[4] = '{1, 1'b0, 3'd7, 8'h00, 4'b0010, 8'h00, 8'h7F, 8'h00, 8'h3C};
    tbl[5] = '{3, 1'b0, 3'd0, 8'h00, 4'b1000, 8'h00, 8'hFE, 8'h00, 8'h81};
    tbl[6] = '{2, 1'b0, 3'd5, 8'h00, 4'b0100, 8'h00, 8'hDF, 8'h00, 8'h5A};

    // Reset with requests pending: nothing may be granted
    Req = 4'hF;
    step();
    step();
    check("rst_grant", 32'(Grant),  32'(0));
    check("rst_done",  32'(Done),   32'(0));
    check("rst_err",   32'(Err),    32'(0));
    check("rst_rd",    32'(RdData), 32'(0));
    check("rst_ce",    32'(RegCE),  32'(0));
    check("rst_cs",    32'(RegCs),  32'(8'hFF));
    check("rst_d",     32'(RegD),   32'(0));
    Req = '0;
    Reset = 1'b1;
    Tick = 1'b1;
    step();

    for (int t = 0; t < 7; t++) run_txn(tbl[t]);

    // Tick gating: ACCESS is held while Tick=0
    Tick = 1'b0;
    Req[1] = 1'b1; ReqWrite[1] = 1'b1; ReqAddr[5:3] = 3'd2; ReqWData[15:8] = 8'h77;
    step();
    Req = '0;
    check("tg_grant0", 32'(Grant), 32'(4'b0010));
    for (int c = 0; c < 5; c++) begin
      step();
      check("tg_hold_grant", 32'(Grant),   32'(4'b0010));
      check("tg_hold_done",  32'(Done),    32'(0));
      check("tg_no_commit",  32'(bank[2]), 32'(8'h22));
    end
    Tick = 1'b1;
    step();
    check("tg_commit", 32'(bank[2]), 32'(8'h77));
    check("tg_done",   32'(Done),    32'(4'b0010));
    check("tg_grant_off", 32'(Grant), 32'(0));
    step();

    // Reset in the middle of an ACCESS with Tick=0
    Tick = 1'b0;
    Req[3] = 1'b1; ReqWrite[3] = 1'b1; ReqAddr[11:9] = 3'd4; ReqWData[31:24] = 8'h99;
    step();
    Req = '0;
    check("mr_grant", 32'(Grant), 32'(4'b1000));
    check("mr_ce",    32'(RegCE), 32'(8'h10));
    Reset = 1'b0;
    step();
    check("mr_grant_off", 32'(Grant),   32'(0));
    check("mr_rd",        32'(RdData),  32'(0));
    check("mr_ce_off",    32'(RegCE),   32'(0));
    check("mr_cs",        32'(RegCs),   32'(8'hFF));
    check("mr_d",         32'(RegD),    32'(0));
    check("mr_done",      32'(Done),    32'(0));
    check("mr_bank",      32'(bank[4]), 32'(8'h44));
    Reset = 1'b1;
    Tick = 1'b1;
    step();
    check("mr_after_grant", 32'(Grant),   32'(0));
    check("mr_after_bank",  32'(bank[4]), 32'(8'h44));

    // Contention: all four request continuously, pointer restarts at 0
    ReqWrite = '0;
    ReqAddr = {3'd4, 3'd3, 3'd2, 3'd1};
    Req = 4'hF;
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] eg, ed;
      step();
      eg = '0;
      ed = '0;
      if ((k - 1) % 3 == 0) eg[((k - 1) / 3) % 4] = 1'b1;
      if (k >= 2 && (k - 2) % 3 == 0) ed[((k - 2) / 3) % 4] = 1'b1;
      check("rr_grant", 32'(Grant), 32'(eg));
      check("rr_done",  32'(Done),  32'(ed));
    end
    Req = '0;
    step();
    step();

    // Out-of-range addresses on a 6-register bank
    Tick_b = 1'b1;
    Req_b[0] = 1'b1; ReqWrite_b[0] = 1'b0; ReqAddr_b[2:0] = 3'd1;
    step();
    Req_b = '0;
    check("inv_pre_grant", 32'(Grant_b), 32'(4'b0001));
    check("inv_pre_cs",    32'(RegCs_b), 32'(6'h3D));
    step();
    check("inv_pre_rd",    32'(RdData_b), 32'(8'h3C));
    check("inv_pre_err",   32'(Err_b),    32'(0));
    step();
    Tick_b = 1'b0;
    Req_b[0] = 1'b1; ReqWrite_b[0] = 1'b1; ReqAddr_b[2:0] = 3'd7; ReqWData_b[7:0] = 8'hEE;
    step();
    Req_b = '0;
    check("inv_w_grant", 32'(Grant_b), 32'(4'b0001));
    check("inv_w_ce",    32'(RegCE_b), 32'(0));
    check("inv_w_cs",    32'(RegCs_b), 32'(6'h3F));
    check("inv_w_d",     32'(RegD_b),  32'(0));
    step();
    check("inv_w_done",  32'(Done_b),   32'(4'b0001));
    check("inv_w_err",   32'(Err_b),    32'(1));
    check("inv_w_ce2",   32'(RegCE_b),  32'(0));
    check("inv_w_cs2",   32'(RegCs_b),  32'(6'h3F));
    check("inv_w_rd",    32'(RdData_b), 32'(8'h3C));
    step();
    check("inv_w_err_off", 32'(Err_b), 32'(0));
    Req_b[2] = 1'b1; ReqWrite_b[2] = 1'b0; ReqAddr_b[8:6] = 3'd6;
    step();
    Req_b = '0;
    check("inv_r_grant", 32'(Grant_b), 32'(4'b0100));
    check("inv_r_cs",    32'(RegCs_b), 32'(6'h3F));
    step();
    check("inv_r_done",  32'(Done_b),   32'(4'b0100));
    check("inv_r_err",   32'(Err_b),    32'(1));
    check("inv_r_rd",    32'(RdData_b), 32'(8'h3C));
    step();

    // Randomized bus-exclusivity run
    prev_done = '0;
    for (int c = 0; c < 10000; c++) begin
      Req      = 4'($urandom);
      ReqWrite = 4'($urandom);
      ReqAddr  = 12'($urandom);
      ReqWData = $urandom;
      Tick     = 1'($urandom_range(0, 1));
      step();
      check("rnd_cs_excl", 32'($countones(~RegCs) <= 1), 32'(1));
      check("rnd_ce_write_access",
            32'((RegCE == 8'h00) ||
                (Grant != 4'h0 && RegCs == 8'hFF && $countones(RegCE) == 1 && Done == 4'h0)),
            32'(1));
      check("rnd_done_pulse", 32'(!(prev_done != 4'h0 && Done != 4'h0)), 32'(1));
      check("rnd_grant_onehot", 32'($countones(Grant) <= 1), 32'(1));
      prev_done = Done;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
